// File: rtl/cu_pkg.sv
// cu_pkg: shared opcodes, FSM state encoding and ALU operation codes for the
// multi-cycle control unit.
package cu_pkg;

  // Instruction opcodes (6-bit field; 16..63 decode as NOP)
  localparam logic [5:0] OP_OR   = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_CMP  = 6'd3;
  localparam logic [5:0] OP_ORI  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5;
  localparam logic [5:0] OP_LW   = 6'd6;
  localparam logic [5:0] OP_SW   = 6'd7;
  localparam logic [5:0] OP_LDW  = 6'd8;
  localparam logic [5:0] OP_SDW  = 6'd9;
  localparam logic [5:0] OP_BZ   = 6'd10;
  localparam logic [5:0] OP_BGZ  = 6'd11;
  localparam logic [5:0] OP_BLZ  = 6'd12;
  localparam logic [5:0] OP_JR   = 6'd13;
  localparam logic [5:0] OP_J    = 6'd14;
  localparam logic [5:0] OP_CLL  = 6'd15;

  // ALU operation select
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_CMP = 2'b11;

  // FSM states
  typedef enum logic [2:0] {
    S_FETCH       = 3'd0,
    S_DECODE      = 3'd1,
    S_EXECUTE     = 3'd2,
    S_MEM         = 3'd3,
    S_WRITE_BACK  = 3'd4,
    S_MEM2        = 3'd5,
    S_WRITE_BACK2 = 3'd6
  } state_t;

endpackage

// File: rtl/cu_branch_cond.sv
// cu_branch_cond: resolves whether the current conditional branch is taken
// from its opcode and the ALU result flags. Non-branch opcodes never take.
module cu_branch_cond
  import cu_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_positive,
  input  logic       i_negative,
  output logic       o_taken
);

  // Select the flag that belongs to each branch flavour
  always_comb begin
    o_taken = 1'b0;
    case (i_opcode)
      OP_BZ:   o_taken = i_zero;
      OP_BGZ:  o_taken = i_positive;
      OP_BLZ:  o_taken = i_negative;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle FSM that sequences FETCH/DECODE/EXECUTE/MEM/
// WRITE_BACK (plus MEM2/WRITE_BACK2 for double-word transfers) and drives
// all datapath enables and selects combinationally from the current state.
//
// Build option: define CU_DOUBLE_WORD_EN to implement LDW/SDW. Without it
// opcodes 8 and 9 behave as NOP, exception is ignored and second_cycle is 0.
//
// o_state mirrors the state register for observation; it is not gated by
// reset so an aborted instruction remains visible during reset.
module control_unit
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       positive,
  input  logic       negative,
  input  logic       exception,
  output logic       pc_write,
  output logic       reg_read,
  output logic       reg_write,
  output logic       reg_write_addr_sel,
  output logic       mem_read,
  output logic       mem_write,
  output logic       second_cycle,
  output logic       branch,
  output logic       jump,
  output logic       jr,
  output logic [1:0] alu_op,
  output logic       alu_src_b,
  output logic       mem_to_reg,
  output logic       stall,
  output logic [2:0] o_state
);

  state_t state;

  logic w_is_alu_reg;
  logic w_is_alu_imm;
  logic w_is_lw;
  logic w_is_sw;
  logic w_is_ldw;
  logic w_is_sdw;
  logic w_is_branch;
  logic w_exc;
  logic w_taken;

`ifdef CU_DOUBLE_WORD_EN
  localparam bit DW_EN = 1'b1;
  assign w_is_ldw = (opcode == OP_LDW);
  assign w_is_sdw = (opcode == OP_SDW);
  assign w_exc    = exception;
`else
  localparam bit DW_EN = 1'b0;
  logic w_unused_exception;
  assign w_is_ldw = 1'b0;
  assign w_is_sdw = 1'b0;
  assign w_exc    = 1'b0;
  assign w_unused_exception = exception;
`endif

  assign w_is_alu_reg = (opcode <= OP_CMP);
  assign w_is_alu_imm = (opcode == OP_ORI) || (opcode == OP_ADDI);
  assign w_is_lw      = (opcode == OP_LW);
  assign w_is_sw      = (opcode == OP_SW);
  assign w_is_branch  = (opcode == OP_BZ) || (opcode == OP_BGZ) || (opcode == OP_BLZ);

  assign o_state = state;

  cu_branch_cond u_branch_cond (
    .i_opcode   (opcode),
    .i_zero     (zero),
    .i_positive (positive),
    .i_negative (negative),
    .o_taken    (w_taken)
  );

  // State register and next-state sequencing; reset aborts any instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (w_is_alu_reg || w_is_alu_imm || w_is_lw || w_is_sw || w_is_branch)
            state <= S_EXECUTE;
          else if ((w_is_ldw || w_is_sdw) && !w_exc)
            state <= S_EXECUTE;
          else if (opcode == OP_CLL)
            state <= S_WRITE_BACK;
          else
            state <= S_FETCH;
        end
        S_EXECUTE: begin
          if (w_is_alu_reg || w_is_alu_imm)
            state <= S_WRITE_BACK;
          else if (w_is_lw || w_is_sw || w_is_ldw || w_is_sdw)
            state <= S_MEM;
          else
            state <= S_FETCH;
        end
        S_MEM: begin
          if (w_is_lw || w_is_ldw)
            state <= S_WRITE_BACK;
          else if (w_is_sdw)
            state <= S_MEM2;
          else
            state <= S_FETCH;
        end
        S_WRITE_BACK:  state <= w_is_ldw ? S_MEM2 : S_FETCH;
        S_MEM2:        state <= w_is_ldw ? S_WRITE_BACK2 : S_FETCH;
        S_WRITE_BACK2: state <= S_FETCH;
        default:       state <= S_FETCH;
      endcase
    end
  end

  // Output decode from state, opcode and flags; everything low during reset
  always_comb begin
    pc_write           = 1'b0;
    reg_read           = 1'b0;
    reg_write          = 1'b0;
    reg_write_addr_sel = 1'b0;
    mem_read           = 1'b0;
    mem_write          = 1'b0;
    second_cycle       = 1'b0;
    branch             = 1'b0;
    jump               = 1'b0;
    jr                 = 1'b0;
    alu_op             = ALU_ADD;
    alu_src_b          = 1'b0;
    mem_to_reg         = 1'b0;
    stall              = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: pc_write = 1'b1;
        S_DECODE: begin
          reg_read = 1'b1;
          if (opcode == OP_JR) begin
            jr       = 1'b1;
            pc_write = 1'b1;
          end else if ((opcode == OP_J) || (opcode == OP_CLL)) begin
            jump     = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_EXECUTE: begin
          if (w_is_alu_reg) begin
            case (opcode)
              OP_OR:   alu_op = ALU_OR;
              OP_SUB:  alu_op = ALU_SUB;
              OP_CMP:  alu_op = ALU_CMP;
              default: alu_op = ALU_ADD;
            endcase
          end else if (w_is_alu_imm || w_is_lw || w_is_sw || w_is_ldw || w_is_sdw) begin
            // Immediate ALU ops and address generation both add the immediate
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
          end else if (w_is_branch) begin
            alu_op   = ALU_SUB;
            branch   = w_taken;
            pc_write = w_taken;
          end
        end
        S_MEM: begin
          mem_read  = w_is_lw || w_is_ldw;
          mem_write = w_is_sw || w_is_sdw;
        end
        S_WRITE_BACK: begin
          reg_write          = 1'b1;
          mem_to_reg         = w_is_lw || w_is_ldw;
          reg_write_addr_sel = (opcode == OP_CLL);
        end
        S_MEM2: begin
          second_cycle = 1'b1;
          stall        = 1'b1;
          mem_read     = w_is_ldw;
          mem_write    = w_is_sdw;
        end
        S_WRITE_BACK2: begin
          second_cycle = 1'b1;
          stall        = 1'b1;
          reg_write    = 1'b1;
          mem_to_reg   = 1'b1;
        end
        default: ;
      endcase
      if (!DW_EN) second_cycle = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed instruction sequences for control_unit. Each
// cycle's expected {state, outputs} vector is queued when the instruction is
// issued; a negedge monitor pops and compares one vector per cycle.
module tb_control_unit;

  localparam int W = 18;

  // Bit positions in the packed {state, outputs} vector
  localparam logic [W-1:0] PCW  = 18'd1 << 14;
  localparam logic [W-1:0] RR   = 18'd1 << 13;
  localparam logic [W-1:0] RW   = 18'd1 << 12;
  localparam logic [W-1:0] RWAS = 18'd1 << 11;
  localparam logic [W-1:0] MR   = 18'd1 << 10;
  localparam logic [W-1:0] MW   = 18'd1 << 9;
  localparam logic [W-1:0] SC   = 18'd1 << 8;
  localparam logic [W-1:0] BR   = 18'd1 << 7;
  localparam logic [W-1:0] JMP  = 18'd1 << 6;
  localparam logic [W-1:0] JRS  = 18'd1 << 5;
  localparam logic [W-1:0] A_SUB = 18'd1 << 3;
  localparam logic [W-1:0] A_OR  = 18'd2 << 3;
  localparam logic [W-1:0] A_CMP = 18'd3 << 3;
  localparam logic [W-1:0] ASB  = 18'd1 << 2;
  localparam logic [W-1:0] M2R  = 18'd1 << 1;
  localparam logic [W-1:0] STL  = 18'd1 << 0;

  localparam logic [W-1:0] S0 = 18'd0 << 15;
  localparam logic [W-1:0] S1 = 18'd1 << 15;
  localparam logic [W-1:0] S2 = 18'd2 << 15;
  localparam logic [W-1:0] S3 = 18'd3 << 15;
  localparam logic [W-1:0] S4 = 18'd4 << 15;
  localparam logic [W-1:0] S5 = 18'd5 << 15;
  localparam logic [W-1:0] S6 = 18'd6 << 15;

  localparam logic [W-1:0] V_F = S0 | PCW;
  localparam logic [W-1:0] V_D = S1 | RR;

  // Clock / reset / DUT signals
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero, positive, negative, exception;
  logic       pc_write, reg_read, reg_write, reg_write_addr_sel;
  logic       mem_read, mem_write, second_cycle, branch, jump, jr;
  logic [1:0] alu_op;
  logic       alu_src_b, mem_to_reg, stall;
  logic [2:0] o_state;

  always #5 clk = ~clk;

  control_unit dut (
    .clk                (clk),
    .reset              (reset),
    .opcode             (opcode),
    .zero               (zero),
    .positive           (positive),
    .negative           (negative),
    .exception          (exception),
    .pc_write           (pc_write),
    .reg_read           (reg_read),
    .reg_write          (reg_write),
    .reg_write_addr_sel (reg_write_addr_sel),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .second_cycle       (second_cycle),
    .branch             (branch),
    .jump               (jump),
    .jr                 (jr),
    .alu_op             (alu_op),
    .alu_src_b          (alu_src_b),
    .mem_to_reg         (mem_to_reg),
    .stall              (stall),
    .o_state            (o_state)
  );

  logic [W-1:0] got;
  assign got = {o_state, pc_write, reg_read, reg_write, reg_write_addr_sel,
                mem_read, mem_write, second_cycle, branch, jump, jr,
                alu_op, alu_src_b, mem_to_reg, stall};

  // Scoreboard
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           errors = 0;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] e;
      string        t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s got %b required %b", t, got, e);
      end
    end
  end

  // Driver tasks
  task automatic push(input string tag, input logic [W-1:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got queue_left=%0d required 0", tag, exp_q.size());
      exp_q.delete();
      tag_q.delete();
    end
    #1;
  endtask

  task automatic go(input logic [5:0] op, input logic z, input logic p,
                    input logic n, input logic e);
    opcode    = op;
    zero      = z;
    positive  = p;
    negative  = n;
    exception = e;
  endtask

  initial begin
    reset = 1'b1;
    go(6'd1, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset: state goes to FETCH, outputs held low while reset is high
    @(posedge clk);
    #1;
    push("reset", S0);
    drain("reset");
    reset = 1'b0;

    // ADD
    go(6'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    push("add.F", V_F); push("add.D", V_D); push("add.E", S2); push("add.WB", S4 | RW);
    drain("add");

    // OR / SUB / CMP
    go(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push("or.F", V_F); push("or.D", V_D); push("or.E", S2 | A_OR); push("or.WB", S4 | RW);
    drain("or");
    go(6'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    push("sub.F", V_F); push("sub.D", V_D); push("sub.E", S2 | A_SUB); push("sub.WB", S4 | RW);
    drain("sub");
    go(6'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    push("cmp.F", V_F); push("cmp.D", V_D); push("cmp.E", S2 | A_CMP); push("cmp.WB", S4 | RW);
    drain("cmp");

    // ORI / ADDI
    go(6'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    push("ori.F", V_F); push("ori.D", V_D); push("ori.E", S2 | ASB); push("ori.WB", S4 | RW);
    drain("ori");
    go(6'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    push("addi.F", V_F); push("addi.D", V_D); push("addi.E", S2 | ASB); push("addi.WB", S4 | RW);
    drain("addi");

    // LW / SW
    go(6'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    push("lw.F", V_F); push("lw.D", V_D); push("lw.E", S2 | ASB);
    push("lw.MEM", S3 | MR); push("lw.WB", S4 | RW | M2R);
    drain("lw");
    go(6'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    push("sw.F", V_F); push("sw.D", V_D); push("sw.E", S2 | ASB); push("sw.MEM", S3 | MW);
    drain("sw");

    // LDW / SDW
`ifdef CU_DOUBLE_WORD_EN
    go(6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    push("ldw.F", V_F); push("ldw.D", V_D); push("ldw.E", S2 | ASB);
    push("ldw.MEM", S3 | MR); push("ldw.WB", S4 | RW | M2R);
    push("ldw.MEM2", S5 | MR | SC | STL); push("ldw.WB2", S6 | RW | M2R | SC | STL);
    drain("ldw");
    go(6'd8, 1'b0, 1'b0, 1'b0, 1'b1);
    push("ldw_exc.F", V_F); push("ldw_exc.D", V_D);
    drain("ldw_exc");
    go(6'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    push("sdw.F", V_F); push("sdw.D", V_D); push("sdw.E", S2 | ASB);
    push("sdw.MEM", S3 | MW); push("sdw.MEM2", S5 | MW | SC | STL);
    drain("sdw");
    go(6'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    push("sdw_exc.F", V_F); push("sdw_exc.D", V_D);
    drain("sdw_exc");
`else
    go(6'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    push("ldw_nop.F", V_F); push("ldw_nop.D", V_D);
    drain("ldw_nop");
    go(6'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    push("sdw_nop.F", V_F); push("sdw_nop.D", V_D);
    drain("sdw_nop");
`endif

    // Branches: taken and not taken, with the other flags as distractors
    go(6'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    push("bz_t.F", V_F); push("bz_t.D", V_D); push("bz_t.E", S2 | A_SUB | BR | PCW);
    drain("bz_t");
    go(6'd10, 1'b0, 1'b1, 1'b1, 1'b0);
    push("bz_n.F", V_F); push("bz_n.D", V_D); push("bz_n.E", S2 | A_SUB);
    drain("bz_n");
    go(6'd11, 1'b0, 1'b1, 1'b0, 1'b0);
    push("bgz_t.F", V_F); push("bgz_t.D", V_D); push("bgz_t.E", S2 | A_SUB | BR | PCW);
    drain("bgz_t");
    go(6'd11, 1'b1, 1'b0, 1'b1, 1'b0);
    push("bgz_n.F", V_F); push("bgz_n.D", V_D); push("bgz_n.E", S2 | A_SUB);
    drain("bgz_n");
    go(6'd12, 1'b0, 1'b0, 1'b1, 1'b0);
    push("blz_t.F", V_F); push("blz_t.D", V_D); push("blz_t.E", S2 | A_SUB | BR | PCW);
    drain("blz_t");
    go(6'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    push("blz_n.F", V_F); push("blz_n.D", V_D); push("blz_n.E", S2 | A_SUB);
    drain("blz_n");

    // Jumps
    go(6'd13, 1'b0, 1'b0, 1'b0, 1'b0);
    push("jr.F", V_F); push("jr.D", V_D | JRS | PCW);
    drain("jr");
    go(6'd14, 1'b0, 1'b0, 1'b0, 1'b0);
    push("j.F", V_F); push("j.D", V_D | JMP | PCW);
    drain("j");
    go(6'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    push("cll.F", V_F); push("cll.D", V_D | JMP | PCW); push("cll.WB", S4 | RW | RWAS);
    drain("cll");

    // NOP opcodes at both ends of the unused range
    go(6'd16, 1'b1, 1'b1, 1'b1, 1'b1);
    push("nop16.F", V_F); push("nop16.D", V_D);
    drain("nop16");
    go(6'd63, 1'b1, 1'b1, 1'b1, 1'b1);
    push("nop63.F", V_F); push("nop63.D", V_D);
    drain("nop63");

    // Reset in the middle of LW: outputs drop, instruction aborted to FETCH
    go(6'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    push("abort.F", V_F); push("abort.D", V_D);
    drain("abort_pre");
    reset = 1'b1;
    push("abort.E_in_reset", S2);
    drain("abort_rst");
    reset = 1'b0;
    go(6'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    push("post.F", V_F); push("post.D", V_D); push("post.E", S2); push("post.WB", S4 | RW);
    drain("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
